// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: sequences PC/IR writes around instruction-memory waits,
// load-use hazards and taken branches, and counts cycles the PC was held.
module fetch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             im_ready,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_memrd,
    input  logic [4:0]       ex_rt,
    input  logic             br_taken,
    input  logic             clr_cnt,
    output logic             PCWr,
    output logic             IRWr,
    output logic             IR_flush,
    output logic             ID_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        IMWAIT = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     cur_state;
    state_t     nxt_state;
    logic       load_use;
    logic [CNT_W-1:0] cnt_q;

    // A load writing r0 never creates a real dependency, so it must not stall.
    assign load_use = ex_memrd && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= BOOT;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        PCWr      = 1'b0;
        IRWr      = 1'b0;
        IR_flush  = 1'b0;
        ID_bubble = 1'b0;
        case (cur_state)
            BOOT: begin
                IR_flush  = 1'b1;
                nxt_state = RUN;
            end
            RUN: begin
                if (br_taken) begin
                    PCWr      = 1'b1;
                    IR_flush  = 1'b1;
                    ID_bubble = 1'b1;
                    nxt_state = FLUSH;
                end else if (load_use) begin
                    ID_bubble = 1'b1;
                end else if (!im_ready) begin
                    nxt_state = IMWAIT;
                end else begin
                    PCWr = 1'b1;
                    IRWr = 1'b1;
                end
            end
            IMWAIT: begin
                if (br_taken) begin
                    PCWr      = 1'b1;
                    IR_flush  = 1'b1;
                    ID_bubble = 1'b1;
                    nxt_state = FLUSH;
                end else if (im_ready) begin
                    PCWr      = 1'b1;
                    IRWr      = 1'b1;
                    nxt_state = RUN;
                end
            end
            FLUSH: begin
                // IR already holds a NOP here, so a load-use match is meaningless.
                if (br_taken) begin
                    PCWr      = 1'b1;
                    IR_flush  = 1'b1;
                    ID_bubble = 1'b1;
                end else if (im_ready) begin
                    PCWr      = 1'b1;
                    IRWr      = 1'b1;
                    nxt_state = RUN;
                end else begin
                    IR_flush = 1'b1;
                end
            end
            default: begin
                IR_flush  = 1'b1;
                nxt_state = BOOT;
            end
        endcase
    end

    // Clear beats increment; the counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_cnt) begin
            cnt_q <= '0;
        end else if ((cur_state != BOOT) && !PCWr && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign state     = cur_state;
    assign stall_cnt = cnt_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 im_ready  input  1  instruction memory data valid this cycle.
REQ-005 id_rs  input  5  rs field of the instruction held in IR.
REQ-006 id_rt  input  5  rt field of the instruction held in IR.
REQ-007 ex_memrd  input  1  EX-stage instruction is a load.
REQ-008 ex_rt  input  5  destination register of the EX-stage load.
REQ-009 br_taken  input  1  branch/jump resolved taken; target is on the PC input mux.
REQ-010 clr_cnt  input  1  synchronous clear of stall_cnt.
REQ-011 PCWr  output  1  PC register write enable.
REQ-012 IRWr  output  1  IR write enable; IR loads im_dout and PC+1.
REQ-013 IR_flush  output  1  forces IR to 0 (NOP) on the next edge.
REQ-014 ID_bubble  output  1  zeroes the ID/EX control word on the next edge.
REQ-015 state  output  2  current FSM state.
REQ-016 stall_cnt  output  CNT_W  count of cycles with PCWr=0 outside BOOT.

Function
REQ-017 FSM encoding SHALL be: BOOT=0, RUN=1, IMWAIT=2, FLUSH=3.
REQ-018 PCWr, IRWr, IR_flush and ID_bubble SHALL be combinational from state and current inputs (Mealy), zero-latency.
REQ-019 load_use SHALL be: ex_memrd and ex_rt!=0 and (ex_rt==id_rs or ex_rt==id_rt).
REQ-020 BOOT: PCWr=0, IRWr=0, IR_flush=1, ID_bubble=0; next state RUN unconditionally.
REQ-021 RUN, priority br_taken > load_use > !im_ready > normal.
REQ-022 RUN+br_taken: PCWr=1, IRWr=0, IR_flush=1, ID_bubble=1; next FLUSH.
REQ-023 RUN+load_use: PCWr=0, IRWr=0, ID_bubble=1, IR_flush=0; stay RUN (IR and PC held).
REQ-024 RUN+!im_ready: PCWr=0, IRWr=0; next IMWAIT.
REQ-025 RUN normal: PCWr=1, IRWr=1, others 0; stay RUN.
REQ-026 IMWAIT: br_taken gives REQ-022 outputs, next FLUSH; else im_ready gives PCWr=1, IRWr=1, next RUN; else all 0, stay IMWAIT.
REQ-027 FLUSH: load_use ignored (IR holds NOP); br_taken gives REQ-022 outputs, stay FLUSH; else im_ready gives PCWr=1, IRWr=1, next RUN; else IR_flush=1, stay FLUSH.
REQ-028 Outputs SHALL never assert IRWr and IR_flush together.
REQ-029 stall_cnt SHALL increment by 1 each cycle with state!=BOOT and PCWr=0, saturating at all-ones.
REQ-030 clr_cnt SHALL clear stall_cnt to 0 and win over a same-cycle increment.
REQ-031 Unreachable encodings SHALL not occur; if forced, next state SHALL be BOOT.

Reset
REQ-032 rst=0 SHALL immediately, without a clock, set state=BOOT and stall_cnt=0; outputs follow REQ-020.
REQ-033 rst=0 in any state mid-operation SHALL abandon the pending fetch or flush; the first edge after release SHALL move BOOT->RUN.

Verification
REQ-034 Reset release, im_ready=1, no hazards -> cycle0 BOOT (IR_flush=1), then RUN with PCWr=IRWr=1 every cycle, stall_cnt=0.
REQ-035 RUN, ex_memrd=1, ex_rt=8, id_rs=8 for 1 cycle -> PCWr=0, IRWr=0, ID_bubble=1 that cycle, stall_cnt +1; ex_rt=0 same case -> no stall.
REQ-036 RUN, im_ready=0 for 3 cycles then 1 -> IMWAIT entered, PCWr=0 for 3 cycles, then PCWr=IRWr=1 and RUN; stall_cnt=3.
REQ-037 RUN br_taken=1 together with load_use=1 and im_ready=0 -> branch wins: PCWr=1, IR_flush=1, ID_bubble=1, next FLUSH; FLUSH with im_ready=1 -> IRWr=1, RUN.
REQ-038 Force stall_cnt to all-ones, hold stall -> stays all-ones; assert clr_cnt in a stall cycle -> 0.
REQ-039 Drop rst in IMWAIT -> state=0 and stall_cnt=0 before the next clk edge.
